// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and load/store (LS).
// LS has priority, bounded by a streak counter. Define MEM_TIMEOUT_EN to abort stalled accesses.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  if (MAX_LS_STREAK < 1 || MAX_LS_STREAK > 15 || TIMEOUT < 1) begin : g_param_check
    $error("mem_port_arbiter: MAX_LS_STREAK must be 1..15 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_LS = 3'd2,
    RESP_IF = 3'd3,
    RESP_LS = 3'd4
  } state_e;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_LS_STREAK);
  localparam logic [3:0] STREAK_SAT   = 4'hF;

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic              grant_ls, grant_if;
  logic              in_busy;
  logic              busy_abort;
  logic [DATA_W-1:0] cap_data;

  // IF only overtakes a pending LS once LS has won MAX_LS_STREAK times in a row.
  assign grant_ls = ls_req && !(if_req && (streak_q == STREAK_LIMIT));
  assign grant_if = if_req && !grant_ls;
  assign in_busy  = (state_q == BUSY_IF) || (state_q == BUSY_LS);

`ifdef MEM_TIMEOUT_EN
  localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  // Abort on the TIMEOUT-th BUSY cycle that passes without an acknowledge.
  assign busy_abort = in_busy && !mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE) begin
      wait_d = '0;
    end else if (in_busy && !mem_ready) begin
      wait_d = wait_q + 1'b1;
    end
    err_d = busy_abort;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign busy_abort = 1'b0;
  assign err        = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    // NOTE: every target gets a hold default first so no path can infer a latch.
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    cap_data    = mem_ready ? mem_rdata : '0;

    unique case (state_q)
      IDLE: begin
        if (grant_ls) begin
          state_d     = BUSY_LS;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_SAT) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_ready || busy_abort) begin
          mem_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_rdata_d = cap_data;
            state_d    = RESP_IF;
          end else begin
            ls_rdata_d = cap_data;
            state_d    = RESP_LS;
          end
        end
      end
      RESP_IF, RESP_LS: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    if_ready  = (state_q == RESP_IF);
    ls_ready  = (state_q == RESP_LS);
    if_rdata  = if_rdata_q;
    ls_rdata  = ls_rdata_q;
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, arbitration order, reset and stall cases.
// Timeout expectations follow MEM_TIMEOUT_EN when it is defined for the build.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr, mem_addr;
  logic [DW-1:0] ls_wdata, if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic          if_ready, ls_ready, mem_req, mem_we, mem_ready, err;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t if_q[$];
  exp_t ls_q[$];
  int   order_q[$];
  int   resp_delay = 0;
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : ~a;
  endfunction

  task automatic push_if(input logic [31:0] d);
    exp_t e;
    e.rdata = d; e.chk = 1'b1;
    if_q.push_back(e);
  endtask

  task automatic push_ls(input logic [31:0] d, input bit chk);
    exp_t e;
    e.rdata = d; e.chk = chk;
    ls_q.push_back(e);
  endtask

  // Memory responder: acknowledges after resp_delay waiting cycles, garbage data otherwise.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    mem_model[32'h10] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (mem_req && wait_cnt >= resp_delay) begin
        mem_ready = 1'b1;
        mem_rdata = mem_read(mem_addr);
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        wait_cnt = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD00000 | 32'($urandom_range(0, 65535));
        wait_cnt  = mem_req ? wait_cnt + 1 : 0;
      end
    end
  end

  // Scoreboard monitor: pops one expectation per ready pulse.
  bit prev_ready = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (if_ready || ls_ready) begin
      check("ready_exclusive", 32'(if_ready & ls_ready), 32'h0);
      check("ready_gap", 32'(prev_ready), 32'h0);
    end
    if (if_ready) begin
      order_q.push_back(0);
      if (if_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL if_sb: got unexpected if_ready, want none");
      end else begin
        e = if_q.pop_front();
        if (e.chk) check("if_rdata", if_rdata, e.rdata);
      end
    end
    if (ls_ready) begin
      order_q.push_back(1);
      if (ls_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL ls_sb: got unexpected ls_ready, want none");
      end else begin
        e = ls_q.pop_front();
        if (e.chk) check("ls_rdata", ls_rdata, e.rdata);
      end
    end
    prev_ready = if_ready | ls_ready;
  end

  // Both requesters ask continuously; n ready pulses must follow LS x MAXS, IF.
  task automatic run_both(input int n, input string tag);
    logic [31:0] ia, la;
    int pulses, cyc;
    pulses = 0; cyc = 0;
    @(negedge clk);
    resp_delay = 0;
    order_q.delete();
    ia = 32'h2000; la = 32'h1000;
    if_addr = ia; ls_addr = la; ls_we = 1'b0;
    push_if(~ia); push_ls(~la, 1'b1);
    if_req = 1'b1; ls_req = 1'b1;
    while (pulses < n && cyc < 400) begin
      @(posedge clk); #1; cyc++;
      if (if_ready) begin
        pulses++; ia += 4; if_addr = ia;
        if (pulses < n) push_if(~ia);
      end
      if (ls_ready) begin
        pulses++; la += 4; ls_addr = la;
        if (pulses < n) push_ls(~la, 1'b1);
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk); #1;
    if_q.delete(); ls_q.delete();
    check({tag, "_pulses"}, 32'(order_q.size()), 32'(n));
    for (int i = 0; i < n && i < order_q.size(); i++)
      check($sformatf("%s_grant%0d", tag, i), 32'(order_q[i]), (i % (MAXS + 1) == MAXS) ? 32'h0 : 32'h1);
  endtask

  vec_t vecs[8];

  initial begin : main
    int cyc, req_cyc, bad, cnt;
    bit seen;
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc, req_cyc, bad, cnt;
    bit seen;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678,  3, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          1, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,          2, 32'hFFFF_FFBB};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          0, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D,  0, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,          0, 32'hCAFE_F00D};
    vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          5, 32'h0000_0003};

    reset = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_readies", {30'h0, if_ready, ls_ready}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single transactions from the vector table.
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      @(negedge clk);
      resp_delay = v.delay;
      if (v.is_ls) begin
        ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
        push_ls(v.exp_rdata, !v.we);
      end else begin
        if_req = 1'b1; if_addr = v.addr;
        push_if(v.exp_rdata);
      end
      cyc = 0; req_cyc = 0; bad = 0; seen = 1'b0;
      while (!seen && cyc < 64) begin
        @(posedge clk); #1; cyc++;
        if (mem_req) begin
          req_cyc++;
          if (mem_we !== (v.is_ls & v.we) || mem_addr !== v.addr ||
              (v.is_ls && v.we && mem_wdata !== v.wdata)) bad++;
        end
        seen = v.is_ls ? ls_ready : if_ready;
      end
      if_req = 1'b0; ls_req = 1'b0;
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'(v.delay + 2));
      check($sformatf("v%0d_mem_req_cycles", i), 32'(req_cyc), 32'(v.delay + 1));
      check($sformatf("v%0d_mem_fields", i), 32'(bad), 32'h0);
      @(posedge clk); #1;
      check($sformatf("v%0d_single_pulse", i), {30'h0, if_ready, ls_ready}, 32'h0);
      if (!v.we) check($sformatf("v%0d_rdata_hold", i), v.is_ls ? ls_rdata : if_rdata, v.exp_rdata);
    end

    run_both(10, "arb");

    // Reset while an LS access is stalled in BUSY with streak already built up.
    @(negedge clk);
    resp_delay = 0;
    if_addr = 32'h3000; ls_addr = 32'h3100; ls_we = 1'b0;
    push_if(~32'h3000); push_ls(~32'h3100, 1'b1);
    if_req = 1'b1; ls_req = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 2 && cyc < 64) begin
      @(posedge clk); #1; cyc++;
      if (ls_ready) begin
        cnt++; ls_addr = ls_addr + 4;
        if (cnt < 2) push_ls(~ls_addr, 1'b1);
        else resp_delay = 100000;
      end
    end
    check("rst_mid_ls_pulses", 32'(cnt), 32'h2);
    cyc = 0;
    while (!mem_req && cyc < 16) begin
      @(posedge clk); #1; cyc++;
    end
    check("rst_mid_busy_reached", 32'(mem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'h0);
    check("rst_mid_readies", {30'h0, if_ready, ls_ready}, 32'h0);
    check("rst_mid_mem_addr", mem_addr, 32'h0);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_release_idle", 32'(mem_req), 32'h0);
    if_q.delete(); ls_q.delete();
    run_both(10, "post_rst");

    // Load whose acknowledge never arrives.
    @(negedge clk);
    resp_delay = 100000;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
`ifdef MEM_TIMEOUT_EN
    push_ls(32'h0, 1'b1);
    cyc = 0; req_cyc = 0; seen = 1'b0;
    while (!seen && cyc < 64) begin
      @(posedge clk); #1; cyc++;
      if (mem_req) req_cyc++;
      if (ls_ready) begin
        seen = 1'b1;
        check("to_err_with_ready", 32'(err), 32'h1);
        check("to_rdata_zero", ls_rdata, 32'h0);
      end
    end
    ls_req = 1'b0;
    check("to_busy_cycles", 32'(req_cyc), 32'(TO));
    check("to_ready_seen", 32'(seen), 32'h1);
    @(posedge clk); #1;
    check("to_err_one_cycle", 32'(err), 32'h0);
    check("to_back_idle", {30'h0, mem_req, ls_ready}, 32'h0);
`else
    push_ls(~32'h300, 1'b1);
    req_cyc = 0; bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (mem_req) req_cyc++;
      if (err || ls_ready) bad++;
    end
    check("stall_mem_req_held", 32'(req_cyc), 32'd40);
    check("stall_no_err_no_ready", 32'(bad), 32'h0);
    resp_delay = 0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(posedge clk); #1; cyc++;
      seen = ls_ready;
    end
    ls_req = 1'b0;
    check("stall_completes", 32'(seen), 32'h1);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
